// File: rtl/ahb_ram_slave.sv
// AHB-Lite slave data RAM: flop-array storage behind a small transfer FSM.
// Decodes address/data phases, applies byte/half/word writes through byte
// enables, returns lane-aligned read words and inserts WAIT_STATES wait cycles.
// Optional build macro: AHB_RAM_ERR_EN enables illegal-transfer detection with
// a two-cycle ERROR response. Without it hresp is tied to OKAY.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transfer in data phase, zero-wait OKAY
// ST_WAIT  | accepted transfer stalled, hreadyout low, counter running
// ST_DATA  | data phase completes this cycle (write commit / read data)
// ST_ERR1  | first ERROR cycle, hreadyout low, hresp high
// ST_ERR2  | second ERROR cycle, hreadyout high, hresp high
module ahb_ram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 2;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_cnt_nxt;
  logic [OW-1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [31:0]   offset;
  logic          accept;
  logic          illegal;
  logic          load_phase;
  logic [3:0]    byte_en;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem [DEPTH];
  logic          unused_bits;

  assign offset   = haddr - BASE_ADDR;
  assign word_idx = addr_q[OW-1:2];

  // A new address phase is only taken when no data phase is stalled or erroring;
  // a transfer shown during ERR2 is deliberately dropped.
  assign accept = hsel & hready & htrans[1] &
                  ((state == ST_IDLE) | (state == ST_DATA));

  assign unused_bits = &{1'b0, htrans[0], hprot, offset};

`ifdef AHB_RAM_ERR_EN
  // Flag transfers with an unsupported size, misalignment or out-of-window offset.
  always_comb begin
    illegal = 1'b0;
    if (hsize > 3'd2)
      illegal = 1'b1;
    if ((hsize == 3'd1) && offset[0])
      illegal = 1'b1;
    if ((hsize == 3'd2) && (offset[1:0] != 2'b00))
      illegal = 1'b1;
    if (offset >= 32'(DEPTH * 4))
      illegal = 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    load_phase   = 1'b0;
    case (state)
      ST_IDLE, ST_DATA: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          load_phase = 1'b1;
          if (illegal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt_nxt == 4'd0)
          state_nxt = ST_DATA;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and address-phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (load_phase) begin
        addr_q  <= offset[OW-1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  // Bus response derived from state only, so reset forces it back at once.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      ST_WAIT: hreadyout = 1'b0;
`ifdef AHB_RAM_ERR_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
`endif
      default: begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
      end
    endcase
  end

  // Byte enables; sizes above word behave as word, misaligned halves lose bits past lane 3.
  always_comb begin
    case (size_q)
      3'd0:    byte_en = 4'b0001 << addr_q[1:0];
      3'd1:    byte_en = 4'b0011 << addr_q[1:0];
      default: byte_en = 4'b1111;
    endcase
  end

  // Write commit at the edge ending DATA. Reset drops the state out of DATA
  // asynchronously, which is what discards a pending write.
  always_ff @(posedge clk) begin
    if ((state == ST_DATA) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[word_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Read word is presented unshifted only in a read DATA cycle.
  always_comb begin
    hrdata = 32'h0;
    if ((state == ST_DATA) && !write_q)
      hrdata = mem[word_idx];
  end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Bench for ahb_ram_slave: three instances (0, 2 and 3 wait states) on a shared
// master, a byte-array reference model, directed plan steps and random traffic.
module tb_ahb_ram_slave;

  localparam int          DEPTH  = 64;
  localparam int          NBYTES = DEPTH * 4;
  localparam logic [31:0] BASE2  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  hsel_v;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [2:0]  rdy_v;
  logic [2:0]  resp_v;
  logic [31:0] rdata0, rdata1, rdata2;

  always #5 clk = ~clk;

  ahb_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hready(rdy_v[0]), .hreadyout(rdy_v[0]), .hresp(resp_v[0]), .hrdata(rdata0));

  ahb_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .reset(reset), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hready(rdy_v[1]), .hreadyout(rdy_v[1]), .hresp(resp_v[1]), .hrdata(rdata1));

  ahb_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE2)) dut2 (
    .clk(clk), .reset(reset), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hready(rdy_v[2]), .hreadyout(rdy_v[2]), .hresp(resp_v[2]), .hrdata(rdata2));

  int          cur;
  logic        cur_rdy, cur_resp;
  logic [31:0] cur_rdata;

  always_comb begin
    case (cur)
      1: begin cur_rdy = rdy_v[1]; cur_resp = resp_v[1]; cur_rdata = rdata1; end
      2: begin cur_rdy = rdy_v[2]; cur_resp = resp_v[2]; cur_rdata = rdata2; end
      default: begin cur_rdy = rdy_v[0]; cur_resp = resp_v[0]; cur_rdata = rdata0; end
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : (inst == 1) ? 2 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int inst);
    return (inst == 2) ? BASE2 : 32'h0;
  endfunction

  // Reference model: plain byte array per instance.
  logic [7:0] mb [3][NBYTES];

  function automatic int word_of(input int inst, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - base_of(inst);
    return int'((off >> 2) & 32'(DEPTH - 1));
  endfunction

  function automatic bit model_illegal(input int inst, input logic [31:0] addr, input logic [2:0] size);
`ifdef AHB_RAM_ERR_EN
    logic [31:0] off;
    off = addr - base_of(inst);
    return (size > 3'd2) || (size == 3'd1 && off[0]) ||
           (size == 3'd2 && off[1:0] != 2'b00) || (off >= 32'(NBYTES));
`else
    return (inst < 0) && (addr == 32'h0) && (size == 3'd7);
`endif
  endfunction

  function automatic logic [31:0] model_read(input int inst, input logic [31:0] addr);
    int w;
    w = word_of(inst, addr);
    return {mb[inst][4*w+3], mb[inst][4*w+2], mb[inst][4*w+1], mb[inst][4*w]};
  endfunction

  task automatic model_write(input int inst, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
    int w, lane0, n, l;
    logic [31:0] off;
    off   = addr - base_of(inst);
    w     = word_of(inst, addr);
    lane0 = int'(off[1:0]);
    if (size >= 3'd2) begin
      for (int k = 0; k < 4; k++) mb[inst][4*w+k] = wdata[8*k +: 8];
    end else begin
      n = (size == 3'd0) ? 1 : 2;
      for (int k = 0; k < n; k++) begin
        l = lane0 + k;
        if (l < 4) mb[inst][4*w+l] = wdata[8*l +: 8];
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       sq[$];
  logic [31:0] r_rdata [256];
  int          r_waits [256];
  logic        r_resp  [256];
  logic        r_wresp [256];

  task automatic push(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    xfer_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
    sq.push_back(t);
  endtask

  // Pipelined AHB master: drives #1 after posedge, samples on negedge.
  task automatic run_seq(input int inst);
    int   ap, dp, nx, budget, w;
    logic wresp, rdy_prev, rdy;
    ap = -1; dp = -1; nx = 0; budget = 0; w = 0; wresp = 1'b0; rdy_prev = 1'b1;
    cur = inst;
    while ((nx < sq.size() || ap >= 0 || dp >= 0) && budget < 2000) begin
      @(posedge clk); #1;
      if (rdy_prev) begin
        dp = ap; w = 0; wresp = 1'b0;
        if (nx < sq.size()) begin ap = nx; nx++; end
        else ap = -1;
      end
      hsel_v = 3'b000;
      hsel_v[inst] = 1'b1;
      if (ap >= 0) begin
        htrans = 2'b10; haddr = sq[ap].addr; hwrite = sq[ap].wr; hsize = sq[ap].size;
      end else begin
        htrans = 2'b00;
      end
      hwdata = (dp >= 0) ? sq[dp].wdata : 32'h0;
      @(negedge clk);
      rdy = cur_rdy;
      if (dp >= 0) begin
        if (rdy) begin
          r_rdata[dp] = cur_rdata; r_resp[dp] = cur_resp;
          r_waits[dp] = w;         r_wresp[dp] = wresp;
        end else begin
          w++;
          wresp |= cur_resp;
          chk($sformatf("stall_rdata_i%0d_x%0d", inst, dp), cur_rdata, 32'h0);
        end
      end else begin
        chk($sformatf("idle_ready_i%0d", inst), 32'(cur_rdy), 32'h1);
        chk($sformatf("idle_resp_i%0d", inst), 32'(cur_resp), 32'h0);
      end
      rdy_prev = rdy;
      budget++;
    end
    chk($sformatf("seq_budget_i%0d", inst), 32'(budget < 2000), 32'h1);
    htrans = 2'b00;
  endtask

  task automatic check_seq(input int inst, input string tag);
    for (int i = 0; i < sq.size(); i++) begin
      if (model_illegal(inst, sq[i].addr, sq[i].size)) begin
        chk($sformatf("%s_errwaits_%0d", tag, i), 32'(r_waits[i]), 32'h1);
        chk($sformatf("%s_err1resp_%0d", tag, i), 32'(r_wresp[i]), 32'h1);
        chk($sformatf("%s_err2resp_%0d", tag, i), 32'(r_resp[i]), 32'h1);
        if (!sq[i].wr) chk($sformatf("%s_errrdata_%0d", tag, i), r_rdata[i], 32'h0);
      end else begin
        chk($sformatf("%s_waits_%0d", tag, i), 32'(r_waits[i]), 32'(ws_of(inst)));
        chk($sformatf("%s_resp_%0d", tag, i), 32'(r_resp[i]), 32'h0);
        if (ws_of(inst) > 0) chk($sformatf("%s_wresp_%0d", tag, i), 32'(r_wresp[i]), 32'h0);
        if (sq[i].wr) model_write(inst, sq[i].addr, sq[i].size, sq[i].wdata);
        else chk($sformatf("%s_rdata_%0d", tag, i), r_rdata[i], model_read(inst, sq[i].addr));
      end
    end
  endtask

  task automatic init_mem(input int inst);
    sq.delete();
    for (int w = 0; w < DEPTH; w++) push(1'b1, base_of(inst) + 32'(4*w), 3'd2, $urandom);
    run_seq(inst);
    check_seq(inst, $sformatf("init%0d", inst));
  endtask

  task automatic rand_seq(input int inst, input int n);
    logic [31:0] off;
    logic [2:0]  size;
    bit          wr;
    sq.delete();
    for (int i = 0; i < n; i++) begin
      wr   = 1'($urandom_range(0, 1));
      size = 3'($urandom_range(0, 2));
      off  = 32'($urandom_range(0, NBYTES - 1));
      if (size == 3'd1) off[0] = 1'b0;
      if (size == 3'd2) off[1:0] = 2'b00;
`ifndef AHB_RAM_ERR_EN
      if ($urandom_range(0, 3) == 0) begin
        size = 3'($urandom_range(0, 7));
        off  = 32'($urandom_range(0, 4*NBYTES - 1));
      end
`endif
      push(wr, base_of(inst) + off, size, $urandom);
    end
    run_seq(inst);
    check_seq(inst, $sformatf("rand%0d", inst));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hsel_v = 3'b000; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hprot = 4'h3; hwdata = 32'h0; cur = 0;

    // Reset, then IDLE with hsel high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(rdy_v), 32'h7);
    chk("rst_resp", 32'(resp_v), 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    reset = 1'b0;
    hsel_v = 3'b001; htrans = 2'b00;
    @(negedge clk);
    chk("idle_sel_ready", 32'(cur_rdy), 32'h1);
    chk("idle_sel_resp", 32'(cur_resp), 32'h0);
    chk("idle_sel_rdata", cur_rdata, 32'h0);

    // Word write then back-to-back read, no wait states.
    sq.delete();
    push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    push(1'b0, 32'h10, 3'd2, 32'h0);
    run_seq(0);
    check_seq(0, "wr_rd");
    chk("wr_rd_data", r_rdata[1], 32'hDEADBEEF);

    // Byte and half lanes.
    sq.delete();
    push(1'b1, 32'h20, 3'd2, 32'h11223344);
    push(1'b1, 32'h22, 3'd0, 32'h00AA0000);
    push(1'b1, 32'h20, 3'd1, 32'h00005566);
    push(1'b0, 32'h20, 3'd2, 32'h0);
    run_seq(0);
    check_seq(0, "lanes");
    chk("lanes_data", r_rdata[3], 32'h11AA5566);

    // Two wait states on a read.
    sq.delete();
    push(1'b1, 32'h30, 3'd2, 32'h0F1E2D3C);
    push(1'b0, 32'h30, 3'd2, 32'h0);
    run_seq(1);
    check_seq(1, "ws2");
    chk("ws2_stall_cycles", 32'(r_waits[1]), 32'h2);
    chk("ws2_data", r_rdata[1], 32'h0F1E2D3C);

    // Misaligned word write at 0x06 (error when checks are built in).
    sq.delete();
    push(1'b1, 32'h04, 3'd2, 32'h01020304);
    run_seq(0);
    check_seq(0, "err_pre");
    sq.delete();
    push(1'b1, 32'h06, 3'd2, 32'hA5A5A5A5);
    run_seq(0);
    check_seq(0, "err_wr");
    sq.delete();
    push(1'b0, 32'h04, 3'd2, 32'h0);
    run_seq(0);
    check_seq(0, "err_rd");
`ifdef AHB_RAM_ERR_EN
    chk("err_rd_unchanged", r_rdata[0], 32'h01020304);
`else
    chk("err_rd_written", r_rdata[0], 32'hA5A5A5A5);
`endif

    // Reset in the second wait cycle of a write.
    sq.delete();
    push(1'b1, BASE2 + 32'h40, 3'd2, 32'h13579BDF);
    run_seq(2);
    check_seq(2, "rst_pre");
    @(posedge clk); #1;
    cur = 2; hsel_v = 3'b100; htrans = 2'b10; haddr = BASE2 + 32'h40; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_mid_wait1", 32'(cur_rdy), 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_wait2", 32'(cur_rdy), 32'h0);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(cur_rdy), 32'h1);
    chk("rst_mid_resp", 32'(cur_resp), 32'h0);
    chk("rst_mid_rdata", cur_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; hsel_v = 3'b000;
    sq.delete();
    push(1'b0, BASE2 + 32'h40, 3'd2, 32'h0);
    run_seq(2);
    check_seq(2, "rst_post");
    chk("rst_post_data", r_rdata[0], 32'h13579BDF);

    // Random traffic against the model.
    init_mem(0);
    rand_seq(0, 40);
    init_mem(1);
    rand_seq(1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
